// File: rtl/noc_local_port_arbiter.sv
// rtl/noc_local_port_arbiter.sv - packet-atomic round-robin arbiter for a NoC router local injection port
// Requesters use void/stop flow control; one registered output stage feeds the router.
module noc_local_port_arbiter #(
   parameter int NumReq = 4,
   parameter int Width  = 34
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NumReq*Width-1:0]     req_data_in,
   input  logic [NumReq-1:0]           req_void_in,
   output logic [NumReq-1:0]           req_stop_out,
   output logic [Width-1:0]            data_out,
   output logic                        data_void_out,
   input  logic                        stop_in,
   output logic                        grant_valid,
   output logic [$clog2(NumReq)-1:0]   grant_idx
);

   localparam int IdxW = $clog2(NumReq);

   typedef enum logic {IDLE, LOCKED} state_e;

   state_e            state_q;
   logic [IdxW-1:0]   rr_ptr_q;
   logic [IdxW-1:0]   owner_q;
   logic [Width-1:0]  out_q;
   logic              out_vld_q;

   logic [Width-1:0]  flits [NumReq];
   logic              sel_valid;
   logic [IdxW-1:0]   sel_idx;
   logic [IdxW:0]     cand_w;
   logic [Width-1:0]  sel_flit;
   logic              can_load;
   logic              accept;

   function automatic logic [IdxW-1:0] next_idx(input logic [IdxW-1:0] i);
      if (i == IdxW'(NumReq - 1)) return '0;
      return i + 1'b1;
   endfunction

   always_comb begin
      for (int i = 0; i < NumReq; i++) flits[i] = req_data_in[i*Width +: Width];
   end

   // Scan from the highest offset down so the lowest offset from rr_ptr wins.
   always_comb begin
      sel_valid = 1'b0;
      sel_idx   = '0;
      cand_w    = '0;
      if (state_q == LOCKED) begin
         sel_valid = !req_void_in[owner_q];
         sel_idx   = owner_q;
      end else begin
         for (int k = NumReq - 1; k >= 0; k--) begin
            cand_w = {1'b0, rr_ptr_q} + (IdxW+1)'(k);
            if (cand_w >= (IdxW+1)'(NumReq)) cand_w = cand_w - (IdxW+1)'(NumReq);
            if (!req_void_in[cand_w[IdxW-1:0]] && flits[cand_w[IdxW-1:0]][Width-1]) begin
               sel_valid = 1'b1;
               sel_idx   = cand_w[IdxW-1:0];
            end
         end
      end
   end

   assign sel_flit = flits[sel_idx];
   assign can_load = !out_vld_q || !stop_in;
   assign accept   = sel_valid && can_load;

   always_comb begin
      req_stop_out = '1;
      if (accept) req_stop_out[sel_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         rr_ptr_q  <= '0;
         owner_q   <= '0;
         out_q     <= '0;
         out_vld_q <= 1'b0;
      end else begin
         if (accept) begin
            out_q     <= sel_flit;
            out_vld_q <= 1'b1;
         end else if (!stop_in) begin
            out_vld_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (accept) begin
                  if (sel_flit[Width-2]) begin
                     rr_ptr_q <= next_idx(sel_idx);
                  end else begin
                     state_q <= LOCKED;
                     owner_q <= sel_idx;
                  end
               end
            end
            LOCKED: begin
               // A stray head from the owner is forwarded; only a tail releases the lock.
               if (accept && sel_flit[Width-2]) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= next_idx(owner_q);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data_out      = out_q;
   assign data_void_out = !out_vld_q;
   assign grant_valid   = (state_q == LOCKED);
   assign grant_idx     = owner_q;

endmodule

// File: doc/noc_local_port_arbiter.md
# noc_local_port_arbiter

Packet-atomic round-robin arbiter sharing the local (P) injection port of one NoC router plane among `NumReq` tile-side requesters (e.g. accelerator DMA, cache, CSR proxy). Each requester presents flits using the router's void/stop flow control. The arbiter:

- grants one requester per packet, head flit through tail flit, with no interleaving;
- forwards flits through a single registered output stage into the router's `data_p_in` / `data_void_in[4]` / `stop_out[4]`.

## Interface

Parameters:
- `NumReq`, default 4: number of requesters, 2..8.
- `Width`, default 34: flit width including the 2-bit preamble. Bit `Width-1` is head, bit `Width-2` is tail; a single-flit packet has both set.

Ports:
- `clk`  in  1  clock. Single clock domain; all state is rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `req_data_in`  in  `NumReq*Width`  flit from requester i at slice `[i*Width +: Width]`.
- `req_void_in`  in  `NumReq`  1 = requester i has no valid flit.
- `req_stop_out`  out  `NumReq`  1 = requester i must hold its flit.
- `data_out`  out  `Width`  flit to router local input.
- `data_void_out`  out  1  1 = `data_out` not valid.
- `stop_in`  in  1  router local stop. 1 = router cannot accept this cycle.
- `grant_valid`  out  1  a packet is locked (state LOCKED).
- `grant_idx`  out  `$clog2(NumReq)`  owner index. Meaningful only when `grant_valid` = 1.

## Operation

- Input transfer on requester i: `req_void_in[i]=0` and `req_stop_out[i]=0` in the same cycle.
- Output transfer: `data_void_out=0` and `stop_in=0` in the same cycle.
- Output stage is one register, `out_q` plus `out_vld`. It can load (`can_load`) when `out_vld=0` or an output transfer occurs this cycle.

State machine:
- IDLE (no owner). Eligible requesters are those with `req_void_in=0` and head bit = 1. Flits without a head bit from non-owners are never accepted; those requesters see stop = 1.
- IDLE: the winner is the first eligible index at or after `rr_ptr`, wrapping modulo `NumReq`. Winner is accepted iff `can_load`.
  - Accepted flit with tail = 0: go to LOCKED, `owner` = winner.
  - Accepted flit with tail = 1 (single-flit packet): stay in IDLE, `rr_ptr` = winner+1 mod `NumReq`.
- LOCKED: only `owner` is eligible, whatever the head bit. Accept when `req_void_in[owner]=0` and `can_load`. Accepted tail flit: go to IDLE, `rr_ptr` = owner+1 mod `NumReq`.
- Head flit from the owner while LOCKED is a protocol error. It is forwarded unchanged and the lock is held until a tail flit arrives.
- `req_stop_out[i]` = 0 only for the current-cycle winner/owner i when `can_load`=1. All other bits are 1. This path is combinational from `stop_in`, `req_void_in` and state. No combinational path from any input to `data_out` or `data_void_out`.
- `grant_valid` = (state == LOCKED). `grant_idx` = `owner`. Both are registered.

## Timing

- Reset (`rst`=0, asynchronous):
  - state IDLE, `rr_ptr`=0, `owner`=0, `out_vld`=0;
  - `data_out`=0, `data_void_out`=1, `grant_valid`=0, `grant_idx`=0.
- With all `req_void_in`=1, `req_stop_out` = all ones.
- Latency: a flit accepted in cycle t appears on `data_out` in cycle t+1 with `data_void_out`=0.
- Throughput: 1 flit/cycle sustained while `stop_in`=0. Load and drain in the same cycle are permitted.
- `stop_in`=1 with `out_vld`=1: `out_q` holds and all `req_stop_out`=1.
- A new packet can win the cycle after the previous tail is accepted, giving back-to-back packets with no bubble.
- Reset asserted mid-packet: the lock is dropped and the output flit is discarded. Requesters must restart packets from a head flit.
- Fairness: every continuously-requesting head waits at most `NumReq-1` packets.

## Test plan

- Reset, then req0 sends a 1-flit packet `{head=1, tail=1}`, payload 0x1234. Required: `data_out` in the next cycle with `data_void_out`=0, `grant_valid` stays 0, `rr_ptr` becomes 1.
- req0 and req2 both present heads with `rr_ptr`=0.
  - req0 sends a 3-flit packet: req0's 3 flits are output contiguously, `req_stop_out[2]`=1 throughout, `grant_idx`=0.
  - req2's head is output in the cycle right after req0's tail.
- All 4 requesters continuously send 2-flit packets. Required grant order 0,1,2,3,0,… and no packet interleaving, checked by a scoreboard per packet.
- `stop_in`=1 for 5 cycles mid-packet. Required: `data_out` stable, `req_stop_out`=4'b1111, no flit lost or duplicated; resumes at 1 flit/cycle when `stop_in` drops.
- req1 presents a non-head flit while IDLE. Required: `req_stop_out[1]`=1 indefinitely and nothing is output.
- Assert `rst`=0 during flit 2 of a 4-flit packet. Required: outputs take reset values immediately. After release, a new head from req3 wins with `rr_ptr`=0 semantics, i.e. req3 is chosen only if req0..req2 are idle.
